add_multi_arb: RTL and testbench



---
 rtl/add_multi_arb.sv | 102 ++++++++++
 tb/tb_add_multi_arb.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_multi_arb.sv
// Round-robin front end for a shared pipelined multi-input adder. It grants one
// operand vector per cycle and carries valid/ID tags alongside the adder pipeline.
module add_multi_arb #(
   parameter int unsigned REQS      = 4,
   parameter int unsigned N         = 8,
   parameter int unsigned ARG_WIDTH = 4,
   parameter int unsigned SUM_WIDTH = 7,
   parameter int unsigned LATENCY   = 3
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            flush,
   input  logic [REQS-1:0]                 req_vld,
   output logic [REQS-1:0]                 req_rdy,
   input  logic [REQS*N*ARG_WIDTH-1:0]     req_arg,
   output logic                            adder_en,
   output logic [N*ARG_WIDTH-1:0]          adder_arg,
   input  logic [SUM_WIDTH-1:0]            adder_sum,
   output logic                            res_vld,
   input  logic                            res_rdy,
   output logic [$clog2(REQS)-1:0]         res_id,
   output logic [SUM_WIDTH-1:0]            res_sum,
   output logic                            busy
);

   localparam int unsigned IDW = $clog2(REQS);
   localparam int unsigned VW  = N * ARG_WIDTH;

   logic [IDW-1:0]               ptr_q, ptr_d;
   logic [LATENCY-1:0]           vld_q, vld_d;
   logic [LATENCY-1:0][IDW-1:0]  id_q, id_d;

   logic           adv_c;
   logic           grant_c;
   logic           accept_c;
   logic [IDW-1:0] gnt_c;

   // The whole adder advances unless a presented result is being held back.
   // Held low during reset so nothing is enabled or accepted.
   assign adv_c    = rst_n && !(res_vld && !res_rdy);
   assign accept_c = grant_c && adv_c && !flush;
   assign adder_en = adv_c;

   // First requesting index at or after the pointer, wrapping at REQS
   always_comb begin
      logic [IDW-1:0] idx;
      idx     = '0;
      grant_c = 1'b0;
      gnt_c   = '0;
      for (int unsigned i = 0; i < REQS; i++) begin
         idx = IDW'((32'(ptr_q) + i) % REQS);
         if (!grant_c && req_vld[idx]) begin
            grant_c = 1'b1;
            gnt_c   = idx;
         end
      end
   end

   always_comb begin
      req_rdy = '0;
      if (accept_c) req_rdy[gnt_c] = 1'b1;
   end

   assign adder_arg = grant_c ? req_arg[32'(gnt_c)*VW +: VW] : '0;

   // Pointer and shadow tag pipeline; flush only clears valids
   always_comb begin
      ptr_d = ptr_q;
      vld_d = vld_q;
      id_d  = id_q;
      if (accept_c) begin
         ptr_d = (gnt_c == IDW'(REQS-1)) ? '0 : gnt_c + IDW'(1);
      end
      if (adv_c) begin
         vld_d[0] = accept_c;
         id_d[0]  = gnt_c;
         for (int unsigned k = 1; k < LATENCY; k++) begin
            vld_d[k] = vld_q[k-1];
            id_d[k]  = id_q[k-1];
         end
      end
      if (flush) vld_d = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
         vld_q <= '0;
         id_q  <= '0;
      end else begin
         ptr_q <= ptr_d;
         vld_q <= vld_d;
         id_q  <= id_d;
      end
   end

   assign res_vld = vld_q[LATENCY-1];
   assign res_id  = id_q[LATENCY-1];
   assign res_sum = adder_sum;
   assign busy    = |vld_q;

endmodule

// File: tb/tb_add_multi_arb.sv
// Bench for add_multi_arb: a 4-requester instance driven from a vector table and
// directed sequences, plus a 3-requester instance under signed random traffic.
module tb_add_multi_arb;

   localparam int unsigned N   = 8;
   localparam int unsigned AW  = 4;
   localparam int unsigned SW  = 7;
   localparam int unsigned LAT = 3;

   logic clk = 1'b0;
   logic rst_n;
   logic flush;
   always #5 clk = ~clk;

   logic [3:0]        vld4, rdy4;
   logic [4*N*AW-1:0] arg4;
   logic              en4, rvld4, rrdy4, busy4;
   logic [N*AW-1:0]   aarg4;
   logic [SW-1:0]     asum4, rsum4;
   logic [1:0]        rid4;

   logic [2:0]        vld3, rdy3;
   logic [3*N*AW-1:0] arg3;
   logic              en3, rvld3, rrdy3, busy3, fl3;
   logic [N*AW-1:0]   aarg3;
   logic [SW-1:0]     asum3, rsum3;
   logic [1:0]        rid3;

   add_multi_arb #(.REQS(4), .N(N), .ARG_WIDTH(AW), .SUM_WIDTH(SW), .LATENCY(LAT)) u4 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .req_vld(vld4), .req_rdy(rdy4), .req_arg(arg4),
      .adder_en(en4), .adder_arg(aarg4), .adder_sum(asum4),
      .res_vld(rvld4), .res_rdy(rrdy4), .res_id(rid4), .res_sum(rsum4),
      .busy(busy4));

   add_multi_arb #(.REQS(3), .N(N), .ARG_WIDTH(AW), .SUM_WIDTH(SW), .LATENCY(LAT)) u3 (
      .clk(clk), .rst_n(rst_n), .flush(fl3),
      .req_vld(vld3), .req_rdy(rdy3), .req_arg(arg3),
      .adder_en(en3), .adder_arg(aarg3), .adder_sum(asum3),
      .res_vld(rvld3), .res_rdy(rrdy3), .res_id(rid3), .res_sum(rsum3),
      .busy(busy3));

   // Behavioural signed adder tree with LAT enabled stages
   function automatic logic [SW-1:0] addf(input logic [N*AW-1:0] a);
      logic signed [SW-1:0] s;
      logic [AW-1:0]        t;
      s = '0;
      for (int i = 0; i < N; i++) begin
         t = a[i*AW +: AW];
         s = s + $signed({{(SW-AW){t[AW-1]}}, t});
      end
      return s;
   endfunction

   logic [SW-1:0] p4 [LAT];
   logic [SW-1:0] p3 [LAT];
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < LAT; k++) begin
            p4[k] <= '0;
            p3[k] <= '0;
         end
      end else begin
         if (en4) begin
            p4[0] <= addf(aarg4);
            for (int k = 1; k < LAT; k++) p4[k] <= p4[k-1];
         end
         if (en3) begin
            p3[0] <= addf(aarg3);
            for (int k = 1; k < LAT; k++) p3[k] <= p3[k-1];
         end
      end
   end
   assign asum4 = p4[LAT-1];
   assign asum3 = p3[LAT-1];

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [15:0] fill4;

   function automatic logic [4*N*AW-1:0] fillarg(input logic [15:0] f);
      logic [4*N*AW-1:0] a;
      a = '0;
      for (int r = 0; r < 4; r++)
         for (int i = 0; i < N; i++)
            a[(r*N+i)*AW +: AW] = f[r*4 +: 4];
      return a;
   endfunction

   // Drive one cycle on u4, check outputs mid-cycle, then advance one edge
   task automatic step4(input string tag, input logic [3:0] v, input logic rr, input logic fl,
                        input logic [3:0] erdy, input logic een, input logic evld,
                        input logic [1:0] eid, input logic [6:0] esum, input logic ebusy);
      vld4  = v;
      rrdy4 = rr;
      flush = fl;
      arg4  = fillarg(fill4);
      #1;
      chk({tag, ".req_rdy"},  32'(rdy4),  32'(erdy));
      chk({tag, ".adder_en"}, 32'(en4),   32'(een));
      chk({tag, ".res_vld"},  32'(rvld4), 32'(evld));
      chk({tag, ".busy"},     32'(busy4), 32'(ebusy));
      if (evld) begin
         chk({tag, ".res_id"},  32'(rid4),  32'(eid));
         chk({tag, ".res_sum"}, 32'(rsum4), 32'(esum));
      end
      tick();
   endtask

   typedef struct {
      logic [3:0]  vld;
      logic        rr;
      logic        fl;
      logic [15:0] fill;
      logic [3:0]  erdy;
      logic        een;
      logic        evld;
      logic [1:0]  eid;
      logic [6:0]  esum;
      logic        ebusy;
   } vec_t;
   vec_t tbl [15];

   typedef struct {
      logic [1:0]    id;
      logic [SW-1:0] sum;
   } res_t;
   res_t q [$];

   int          sent [3];
   int          got_id [3];
   logic        pend [3];
   logic [31:0] a3 [3];
   int          es [3];
   int          ptr3, wraps, total_got, g, val;
   logic [2:0]  acc;
   res_t        r;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      // single requester 2, then all four streaming starting from pointer 3
      tbl[0]  = '{4'b0100, 1'b1, 1'b0, 16'h0100, 4'b0100, 1'b1, 1'b0, 2'd0, 7'd0,  1'b0};
      tbl[1]  = '{4'b0000, 1'b1, 1'b0, 16'h0100, 4'b0000, 1'b1, 1'b0, 2'd0, 7'd0,  1'b1};
      tbl[2]  = '{4'b0000, 1'b1, 1'b0, 16'h0100, 4'b0000, 1'b1, 1'b0, 2'd0, 7'd0,  1'b1};
      tbl[3]  = '{4'b0000, 1'b1, 1'b0, 16'h0100, 4'b0000, 1'b1, 1'b1, 2'd2, 7'd8,  1'b1};
      tbl[4]  = '{4'b0000, 1'b1, 1'b0, 16'h0100, 4'b0000, 1'b1, 1'b0, 2'd0, 7'd0,  1'b0};
      tbl[5]  = '{4'b1111, 1'b1, 1'b0, 16'h3210, 4'b1000, 1'b1, 1'b0, 2'd0, 7'd0,  1'b0};
      tbl[6]  = '{4'b1111, 1'b1, 1'b0, 16'h3210, 4'b0001, 1'b1, 1'b0, 2'd0, 7'd0,  1'b1};
      tbl[7]  = '{4'b1111, 1'b1, 1'b0, 16'h3210, 4'b0010, 1'b1, 1'b0, 2'd0, 7'd0,  1'b1};
      tbl[8]  = '{4'b1111, 1'b1, 1'b0, 16'h3210, 4'b0100, 1'b1, 1'b1, 2'd3, 7'd24, 1'b1};
      tbl[9]  = '{4'b1111, 1'b1, 1'b0, 16'h3210, 4'b1000, 1'b1, 1'b1, 2'd0, 7'd0,  1'b1};
      tbl[10] = '{4'b1111, 1'b1, 1'b0, 16'h3210, 4'b0001, 1'b1, 1'b1, 2'd1, 7'd8,  1'b1};
      tbl[11] = '{4'b0000, 1'b1, 1'b0, 16'h3210, 4'b0000, 1'b1, 1'b1, 2'd2, 7'd16, 1'b1};
      tbl[12] = '{4'b0000, 1'b1, 1'b0, 16'h3210, 4'b0000, 1'b1, 1'b1, 2'd3, 7'd24, 1'b1};
      tbl[13] = '{4'b0000, 1'b1, 1'b0, 16'h3210, 4'b0000, 1'b1, 1'b1, 2'd0, 7'd0,  1'b1};
      tbl[14] = '{4'b0000, 1'b1, 1'b0, 16'h3210, 4'b0000, 1'b1, 1'b0, 2'd0, 7'd0,  1'b0};

      rst_n = 1'b0; flush = 1'b0; fl3 = 1'b0;
      vld4 = 4'b1111; rrdy4 = 1'b1; fill4 = 16'h3210; arg4 = fillarg(fill4);
      vld3 = '0; rrdy3 = 1'b1; arg3 = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset.req_rdy",  32'(rdy4),  32'd0);
      chk("reset.adder_en", 32'(en4),   32'd0);
      chk("reset.res_vld",  32'(rvld4), 32'd0);
      chk("reset.busy",     32'(busy4), 32'd0);
      vld4 = '0;
      #3 rst_n = 1'b1;
      tick();

      for (int v = 0; v < 15; v++) begin
         fill4 = tbl[v].fill;
         step4($sformatf("vec%0d", v), tbl[v].vld, tbl[v].rr, tbl[v].fl, tbl[v].erdy,
               tbl[v].een, tbl[v].evld, tbl[v].eid, tbl[v].esum, tbl[v].ebusy);
      end

      // backpressure: five stalled cycles with a result presented
      step4("bp_a", 4'b1111, 1'b1, 1'b0, 4'b0010, 1'b1, 1'b0, 2'd0, 7'd0, 1'b0);
      step4("bp_b", 4'b1111, 1'b1, 1'b0, 4'b0100, 1'b1, 1'b0, 2'd0, 7'd0, 1'b1);
      step4("bp_c", 4'b1111, 1'b1, 1'b0, 4'b1000, 1'b1, 1'b0, 2'd0, 7'd0, 1'b1);
      for (int s = 0; s < 5; s++)
         step4($sformatf("bp_stall%0d", s), 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd1, 7'd8, 1'b1);
      step4("bp_r0", 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd1, 7'd8,  1'b1);
      step4("bp_r1", 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd2, 7'd16, 1'b1);
      step4("bp_r2", 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd3, 7'd24, 1'b1);
      step4("bp_r3", 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 7'd0,  1'b0);

      // flush with three in flight; presented result and requester 1 both blocked
      step4("fl_a",     4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1, 1'b0, 2'd0, 7'd0, 1'b0);
      step4("fl_b",     4'b1111, 1'b1, 1'b0, 4'b0010, 1'b1, 1'b0, 2'd0, 7'd0, 1'b1);
      step4("fl_c",     4'b1111, 1'b1, 1'b0, 4'b0100, 1'b1, 1'b0, 2'd0, 7'd0, 1'b1);
      step4("fl_flush", 4'b0010, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b1, 2'd0, 7'd0, 1'b1);
      step4("fl_d",     4'b0010, 1'b1, 1'b0, 4'b0010, 1'b1, 1'b0, 2'd0, 7'd0, 1'b0);
      step4("fl_e",     4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 7'd0, 1'b1);
      step4("fl_f",     4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 7'd0, 1'b1);
      step4("fl_g",     4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd1, 7'd8, 1'b1);
      step4("fl_h",     4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 7'd0, 1'b0);

      // asynchronous reset mid-cycle with two in flight and pointer at 2
      step4("rs_a", 4'b0100, 1'b1, 1'b0, 4'b0100, 1'b1, 1'b0, 2'd0, 7'd0, 1'b0);
      step4("rs_b", 4'b0010, 1'b1, 1'b0, 4'b0010, 1'b1, 1'b0, 2'd0, 7'd0, 1'b1);
      vld4 = 4'b1111;
      #1;
      chk("rs_pre.req_rdy", 32'(rdy4),  32'b0100);
      chk("rs_pre.busy",    32'(busy4), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rs_low.req_rdy",  32'(rdy4),  32'd0);
      chk("rs_low.adder_en", 32'(en4),   32'd0);
      chk("rs_low.res_vld",  32'(rvld4), 32'd0);
      chk("rs_low.busy",     32'(busy4), 32'd0);
      @(posedge clk);
      #3;
      vld4  = '0;
      rst_n = 1'b1;
      tick();
      for (int s = 0; s < 4; s++)
         step4($sformatf("rs_idle%0d", s), 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 7'd0, 1'b0);
      step4("rs_first", 4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1, 1'b0, 2'd0, 7'd0, 1'b0);
      vld4 = '0;

      // three requesters, signed operands, random result backpressure
      ptr3 = 0; wraps = 0; total_got = 0;
      for (int i = 0; i < 3; i++) begin
         sent[i] = 0; got_id[i] = 0; pend[i] = 1'b0; a3[i] = '0; es[i] = 0;
      end
      for (int cyc = 0; cyc < 20000 && total_got < 411; cyc++) begin
         for (int i = 0; i < 3; i++) begin
            if (!pend[i] && sent[i] < 137 && $urandom_range(0, 3) != 0) begin
               es[i] = 0;
               for (int j = 0; j < N; j++) begin
                  val = int'($urandom_range(0, 2)) - 1;
                  a3[i][j*AW +: AW] = 4'(val);
                  es[i] += val;
               end
               pend[i] = 1'b1;
            end
         end
         vld3  = {pend[2], pend[1], pend[0]};
         arg3  = {a3[2], a3[1], a3[0]};
         rrdy3 = ($urandom_range(0, 3) != 0);
         #1;
         acc = vld3 & rdy3;
         if (acc != 3'b000) begin
            g = -1;
            for (int k = 0; k < 3; k++)
               if (g < 0 && vld3[(ptr3 + k) % 3]) g = (ptr3 + k) % 3;
            chk("u3_grant", 32'(acc), 32'(3'b001 << g));
            q.push_back('{2'(g), SW'(es[g])});
            pend[g] = 1'b0;
            sent[g]++;
            if (g == 2) wraps++;
            ptr3 = (g + 1) % 3;
         end
         if (rvld3 && rrdy3) begin
            if (q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL u3_extra_result: got id %0d with nothing outstanding", rid3);
            end else begin
               r = q.pop_front();
               chk("u3_res_id",  32'(rid3),  32'(r.id));
               chk("u3_res_sum", 32'(rsum3), 32'(r.sum));
               got_id[r.id]++;
               total_got++;
            end
         end
         tick();
      end
      chk("u3_total",  32'(total_got), 32'd411);
      chk("u3_req0",   32'(got_id[0]), 32'd137);
      chk("u3_req1",   32'(got_id[1]), 32'd137);
      chk("u3_req2",   32'(got_id[2]), 32'd137);
      chk("u3_wrap_2_to_0", 32'(wraps > 0), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
